cajero_atm_ctrl: RTL and testbench
==================================

// Module: cajero_atm_ctrl
// PURPOSE
//   ATM transaction controller FSM. Accepts a card, collects a 4-digit PIN one
//   BCD digit at a time and checks it against the card PIN. Then performs a
//   deposit or withdrawal on an internal 64-bit balance.
//   It flags wrong PINs, warns on the 2nd failure and locks on the 3rd.
//   Driven directly by the front-panel/stimulus block; all outputs are registered.
// PARAMETERS
//   BALANCE_INICIAL  64'd1000  balance loaded on reset (64-bit unsigned)
// PORTS
//   CLK                   in   1   clock, rising edge
//   Reset                 in   1   asynchronous, active-low reset
//   Tarjeta_recibida      in   1   card inserted; level, sampled in ESPERA_TARJETA
//   PIN                   in   16  correct PIN, 4 BCD digits, [15:12] = first digit
//   Digito                in   4   entered digit, valid when Digito_STB=1
//   Digito_STB            in   1   1-cycle strobe, one per digit
//   Tipo_trans            in   1   0 = deposit, 1 = withdrawal; sampled with Monto_STB
//   Monto                 in   32  amount, unsigned; valid when Monto_STB=1
//   Monto_STB             in   1   1-cycle strobe, amount valid
//   Balance_actualizado   out  1   1-cycle pulse: balance changed
//   Entregar_dinero       out  1   1-cycle pulse: dispense cash (withdrawal OK)
//   Fondos_insuficientes  out  1   1-cycle pulse: withdrawal rejected
//   PIN_incorrecto        out  1   1-cycle pulse: entered PIN mismatched
//   Advertencia           out  1   level: two consecutive failures, one try left
//   Bloqueo               out  1   level: locked after 3rd failure
// BEHAVIOUR
//   Reset (Reset=0, async): state=ESPERA_TARJETA, balance=BALANCE_INICIAL,
//     fail count=0, digit count=0, digit shift reg=0, all outputs 0.
//   States:
//     ESPERA_TARJETA -> ESPERA_PIN when Tarjeta_recibida=1 at a clock edge.
//     ESPERA_PIN: on each edge with Digito_STB=1, shift Digito into a 16-bit reg
//       (reg = {reg[11:0],Digito}) and increment the digit count.
//       - Digit count does not advance without a strobe.
//       - On the 4th digit, compare {reg[11:0],Digito} with PIN on that same edge,
//         then clear the digit count (1-cycle latency from the strobe).
//       - Match: fail count=0, Advertencia=0, go to ESPERA_MONTO.
//       - Mismatch: PIN_incorrecto pulses 1 cycle; fail count++; stay in
//         ESPERA_PIN.
//       - Fail count 2: Advertencia=1.
//       - Fail count 3: go to BLOQUEO.
//     ESPERA_MONTO: on the edge with Monto_STB=1, latch Tipo_trans and Monto,
//       then execute in the same edge:
//       - Deposit: balance += zero-extended Monto (mod 2^64);
//         Balance_actualizado pulses 1 cycle.
//       - Withdrawal, Monto <= balance: balance -= Monto; Balance_actualizado
//         and Entregar_dinero pulse together for 1 cycle.
//       - Withdrawal, Monto > balance: balance unchanged;
//         Fondos_insuficientes pulses 1 cycle.
//       - After any of these cases, return to ESPERA_TARJETA.
//     BLOQUEO: Bloqueo=1, Advertencia=0.
//       - All inputs are ignored; leave only via Reset.
//   Rules:
//     - Digito_STB is ignored outside ESPERA_PIN.
//     - Monto_STB is ignored outside ESPERA_MONTO.
//     - Tarjeta_recibida is ignored outside ESPERA_TARJETA; card removal does not
//       abort a session.
//     - Fail count persists across sessions until a correct PIN or Reset.
//     - Digito values >9 are compared as-is (no BCD check).
//     - Withdrawal of exactly the balance is allowed (balance -> 0).
//     - Amount 0 is a valid transaction (pulses as above).
//     - Simultaneous Digito_STB and Monto_STB: only the strobe relevant to the
//       current state is used.
//     - Reset mid-session: immediate return to reset values, including balance.
// TESTING
//   1. Reset, card, PIN=16'h1234, digits 1,2,3,4 -> no PIN_incorrecto;
//      Monto=500, Tipo_trans=0 -> Balance_actualizado 1 cycle; balance 1500.
//   2. After 1, card, correct PIN, withdraw 1500 -> Balance_actualizado and
//      Entregar_dinero 1 cycle; balance 0.
//      Next session: withdraw 1 -> Fondos_insuficientes only.
//   3. Card, digits 1,2,3,5 -> PIN_incorrecto 1 cycle.
//      Again wrong -> PIN_incorrecto, Advertencia=1.
//      Then 1,2,3,4 -> Advertencia=0, transaction accepted.
//   4. Three wrong PIN entries -> Bloqueo=1 after 3rd.
//      Further correct digits and Monto_STB give no pulses; Reset clears Bloqueo.
//   5. Reset asserted mid PIN entry (2 digits in) -> all outputs 0,
//      state ESPERA_TARJETA; a fresh 4-digit entry then works normally.

Source files
------------

// File: rtl/cajero_atm_ctrl.sv
// ATM transaction controller: card detect, 4-digit PIN entry with retry/lockout,
// then a single deposit or withdrawal against an internal 64-bit balance.
module cajero_atm_ctrl #(
    parameter logic [63:0] BALANCE_INICIAL = 64'd1000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Tarjeta_recibida,
    input  logic [15:0] PIN,
    input  logic [3:0]  Digito,
    input  logic        Digito_STB,
    input  logic        Tipo_trans,
    input  logic [31:0] Monto,
    input  logic        Monto_STB,
    output logic        Balance_actualizado,
    output logic        Entregar_dinero,
    output logic        Fondos_insuficientes,
    output logic        PIN_incorrecto,
    output logic        Advertencia,
    output logic        Bloqueo
);

    // state          | meaning
    // ESPERA_TARJETA | idle, waiting for a card
    // ESPERA_PIN     | collecting PIN digits, checking every 4th
    // ESPERA_MONTO   | PIN accepted, waiting for the amount strobe
    // BLOQUEO        | third consecutive wrong PIN, only Reset leaves
    typedef enum logic [1:0] {
        ESPERA_TARJETA,
        ESPERA_PIN,
        ESPERA_MONTO,
        BLOQUEO
    } state_t;

    state_t      state;
    logic [63:0] balance;
    logic [1:0]  fail_cnt;
    logic [1:0]  digit_cnt;
    logic [15:0] digit_reg;
    logic [15:0] entered_pin;
    logic [63:0] monto_ext;

    assign entered_pin = {digit_reg[11:0], Digito};
    assign monto_ext   = {32'd0, Monto};

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state                <= ESPERA_TARJETA;
            balance              <= BALANCE_INICIAL;
            fail_cnt             <= 2'd0;
            digit_cnt            <= 2'd0;
            digit_reg            <= 16'd0;
            Balance_actualizado  <= 1'b0;
            Entregar_dinero      <= 1'b0;
            Fondos_insuficientes <= 1'b0;
            PIN_incorrecto       <= 1'b0;
            Advertencia          <= 1'b0;
            Bloqueo              <= 1'b0;
        end else begin
            Balance_actualizado  <= 1'b0;
            Entregar_dinero      <= 1'b0;
            Fondos_insuficientes <= 1'b0;
            PIN_incorrecto       <= 1'b0;

            case (state)
                ESPERA_TARJETA: begin
                    if (Tarjeta_recibida) begin
                        state <= ESPERA_PIN;
                    end
                end

                ESPERA_PIN: begin
                    if (Digito_STB) begin
                        digit_reg <= entered_pin;
                        if (digit_cnt == 2'd3) begin
                            digit_cnt <= 2'd0;
                            if (entered_pin == PIN) begin
                                fail_cnt    <= 2'd0;
                                Advertencia <= 1'b0;
                                state       <= ESPERA_MONTO;
                            end else begin
                                PIN_incorrecto <= 1'b1;
                                if (fail_cnt == 2'd2) begin
                                    fail_cnt    <= 2'd3;
                                    Advertencia <= 1'b0;
                                    Bloqueo     <= 1'b1;
                                    state       <= BLOQUEO;
                                end else begin
                                    fail_cnt    <= fail_cnt + 2'd1;
                                    Advertencia <= (fail_cnt == 2'd1);
                                end
                            end
                        end else begin
                            digit_cnt <= digit_cnt + 2'd1;
                        end
                    end
                end

                ESPERA_MONTO: begin
                    if (Monto_STB) begin
                        state <= ESPERA_TARJETA;
                        if (!Tipo_trans) begin
                            balance             <= balance + monto_ext;
                            Balance_actualizado <= 1'b1;
                        end else if (monto_ext <= balance) begin
                            balance             <= balance - monto_ext;
                            Balance_actualizado <= 1'b1;
                            Entregar_dinero     <= 1'b1;
                        end else begin
                            Fondos_insuficientes <= 1'b1;
                        end
                    end
                end

                BLOQUEO: begin
                    Bloqueo     <= 1'b1;
                    Advertencia <= 1'b0;
                end

                default: state <= ESPERA_TARJETA;
            endcase
        end
    end

endmodule

// File: tb/tb_cajero_atm_ctrl.sv
// Self-checking bench for cajero_atm_ctrl: directed scenarios plus randomized
// sessions checked against a behavioural model (balance, failure count, lock).
module tb_cajero_atm_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Tarjeta_recibida;
    logic [15:0] PIN;
    logic [3:0]  Digito;
    logic        Digito_STB;
    logic        Tipo_trans;
    logic [31:0] Monto;
    logic        Monto_STB;
    logic        Balance_actualizado;
    logic        Entregar_dinero;
    logic        Fondos_insuficientes;
    logic        PIN_incorrecto;
    logic        Advertencia;
    logic        Bloqueo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_bal;
    int          m_fails;
    bit          m_locked;

    cajero_atm_ctrl #(.BALANCE_INICIAL(64'd1000)) dut (
        .CLK                 (CLK),
        .Reset               (Reset),
        .Tarjeta_recibida    (Tarjeta_recibida),
        .PIN                 (PIN),
        .Digito              (Digito),
        .Digito_STB          (Digito_STB),
        .Tipo_trans          (Tipo_trans),
        .Monto               (Monto),
        .Monto_STB           (Monto_STB),
        .Balance_actualizado (Balance_actualizado),
        .Entregar_dinero     (Entregar_dinero),
        .Fondos_insuficientes(Fondos_insuficientes),
        .PIN_incorrecto      (PIN_incorrecto),
        .Advertencia         (Advertencia),
        .Bloqueo             (Bloqueo)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_bal    = 64'd1000;
        m_fails  = 0;
        m_locked = 0;
    endtask

    task automatic model_pin(input logic [15:0] entered, input logic [15:0] pin,
                             output logic exp_pi, output logic exp_adv,
                             output logic exp_blq, output bit ok);
        if (entered == pin) begin
            m_fails = 0;
            exp_pi  = 1'b0;
            ok      = 1;
        end else begin
            m_fails = m_fails + 1;
            exp_pi  = 1'b1;
            ok      = 0;
            if (m_fails >= 3) m_locked = 1;
        end
        exp_adv = (m_fails == 2) && !m_locked;
        exp_blq = m_locked;
    endtask

    // expected {Balance_actualizado, Entregar_dinero, Fondos_insuficientes}
    task automatic model_txn(input bit tipo, input logic [31:0] amt, output logic [2:0] exp);
        if (!tipo) begin
            m_bal = m_bal + {32'd0, amt};
            exp   = 3'b100;
        end else if ({32'd0, amt} <= m_bal) begin
            m_bal = m_bal - {32'd0, amt};
            exp   = 3'b110;
        end else begin
            exp   = 3'b001;
        end
    endtask

    // ---------------- stimulus drivers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic insert_card(input bit noise);
        if (noise) begin
            repeat ($urandom_range(0, 2)) begin
                Digito     = 4'($urandom);
                Digito_STB = 1'b1;
                Monto      = $urandom;
                Monto_STB  = 1'($urandom_range(0, 1));
                step();
                Digito_STB = 1'b0;
                Monto_STB  = 1'b0;
            end
        end
        Tarjeta_recibida = 1'b1;
        step();
        Tarjeta_recibida = 1'b0;
    endtask

    // early: any PIN_incorrecto seen before the 4th-digit result or in the cycle after it
    task automatic do_pin(input logic [15:0] entered, input bit noise,
                          output logic pi, output logic adv, output logic blq,
                          output logic early);
        early = 1'b0;
        pi = 1'b0; adv = 1'b0; blq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Digito     = entered[15-4*i -: 4];
            Digito_STB = 1'b1;
            if (noise && $urandom_range(0, 1) == 1) begin
                Monto_STB  = 1'b1;
                Monto      = $urandom;
                Tipo_trans = 1'($urandom_range(0, 1));
            end
            step();
            Digito_STB = 1'b0;
            Monto_STB  = 1'b0;
            if (i == 3) begin
                pi  = PIN_incorrecto;
                adv = Advertencia;
                blq = Bloqueo;
            end else begin
                early = early | PIN_incorrecto;
            end
            if (noise) begin
                repeat ($urandom_range(0, 2)) begin
                    Digito = 4'($urandom);
                    step();
                    early = early | PIN_incorrecto;
                end
            end
        end
        step();
        early = early | PIN_incorrecto;
    endtask

    task automatic do_txn(input bit tipo, input logic [31:0] amt, input bit noise,
                          output logic [2:0] obs, output logic [2:0] after);
        if (noise) begin
            repeat ($urandom_range(0, 2)) begin
                Digito     = 4'($urandom);
                Digito_STB = 1'b1;
                step();
                Digito_STB = 1'b0;
            end
        end
        Tipo_trans = tipo;
        Monto      = amt;
        Monto_STB  = 1'b1;
        Digito_STB = noise;
        step();
        Monto_STB  = 1'b0;
        Digito_STB = 1'b0;
        obs = {Balance_actualizado, Entregar_dinero, Fondos_insuficientes};
        step();
        after = {Balance_actualizado, Entregar_dinero, Fondos_insuficientes};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if ({Balance_actualizado, Entregar_dinero, Fondos_insuficientes,
             PIN_incorrecto, Advertencia, Bloqueo} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {Balance_actualizado, Entregar_dinero, Fondos_insuficientes,
                      PIN_incorrecto, Advertencia, Bloqueo});
        end
        Reset = 1'b1;
        step();
    endtask

    task automatic test_deposit();
        logic pi, adv, blq, early, epi, eadv, eblq;
        logic [2:0] obs, after, exp;
        bit ok;
        PIN = 16'h1234;
        insert_card(0);
        model_pin(16'h1234, PIN, epi, eadv, eblq, ok);
        do_pin(16'h1234, 0, pi, adv, blq, early);
        n_checks++;
        if ({pi, early} !== {epi, 1'b0}) begin
            n_fail++;
            $display("FAIL deposit_pin: got pi=%b early=%b expected pi=%b early=0", pi, early, epi);
        end
        model_txn(0, 32'd500, exp);
        do_txn(0, 32'd500, 0, obs, after);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL deposit_500: got %b expected %b", obs, exp);
        end
        n_checks++;
        if (after !== 3'b000) begin
            n_fail++;
            $display("FAIL deposit_pulse_width: got %b expected 000", after);
        end
    endtask

    task automatic test_withdraw();
        logic pi, adv, blq, early, epi, eadv, eblq;
        logic [2:0] obs, after, exp;
        bit ok;
        logic [31:0] amts [3] = '{32'd1500, 32'd1, 32'd0};
        PIN = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            insert_card(0);
            model_pin(16'h1234, PIN, epi, eadv, eblq, ok);
            do_pin(16'h1234, 0, pi, adv, blq, early);
            model_txn(1, amts[k], exp);
            do_txn(1, amts[k], 0, obs, after);
            n_checks++;
            if (obs !== exp || after !== 3'b000) begin
                n_fail++;
                $display("FAIL withdraw_%0d: got %b/%b expected %b/000", amts[k], obs, after, exp);
            end
        end
    endtask

    task automatic test_warning();
        logic pi, adv, blq, early, epi, eadv, eblq;
        logic [2:0] obs, after, exp;
        bit ok;
        logic [15:0] seq [3] = '{16'h1235, 16'h1235, 16'h1234};
        PIN = 16'h1234;
        insert_card(0);
        for (int k = 0; k < 3; k++) begin
            model_pin(seq[k], PIN, epi, eadv, eblq, ok);
            do_pin(seq[k], 0, pi, adv, blq, early);
            n_checks++;
            if ({pi, adv, blq, early} !== {epi, eadv, eblq, 1'b0}) begin
                n_fail++;
                $display("FAIL warning_attempt%0d: got pi/adv/blq/early=%b%b%b%b expected %b%b%b0",
                         k, pi, adv, blq, early, epi, eadv, eblq);
            end
        end
        model_txn(0, 32'd10, exp);
        do_txn(0, 32'd10, 0, obs, after);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL warning_txn: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_lockout();
        logic pi, adv, blq, early, epi, eadv, eblq;
        logic [2:0] obs, after;
        bit ok;
        PIN = 16'h1234;
        insert_card(0);
        for (int k = 0; k < 3; k++) begin
            model_pin(16'h9F00 + 16'(k), PIN, epi, eadv, eblq, ok);
            do_pin(16'h9F00 + 16'(k), 0, pi, adv, blq, early);
            n_checks++;
            if ({pi, adv, blq} !== {epi, eadv, eblq}) begin
                n_fail++;
                $display("FAIL lock_attempt%0d: got pi/adv/blq=%b%b%b expected %b%b%b",
                         k, pi, adv, blq, epi, eadv, eblq);
            end
        end
        do_pin(16'h1234, 0, pi, adv, blq, early);
        n_checks++;
        if ({pi, adv, blq, early} !== 4'b0010) begin
            n_fail++;
            $display("FAIL locked_digits: got pi/adv/blq/early=%b%b%b%b expected 0010", pi, adv, blq, early);
        end
        do_txn(1, 32'd5, 0, obs, after);
        n_checks++;
        if ({obs, after, Bloqueo} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL locked_monto: got %b%b blq=%b expected 000000 blq=1", obs, after, Bloqueo);
        end
        insert_card(0);
        Reset = 1'b0;
        #3;
        model_reset();
        n_checks++;
        if (Bloqueo !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_reset_clear: got %b expected 0", Bloqueo);
        end
        Reset = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        logic pi, adv, blq, early, epi, eadv, eblq;
        logic [2:0] obs, after, exp;
        bit ok;
        PIN = 16'h4321;
        insert_card(0);
        model_pin(16'h4321, PIN, epi, eadv, eblq, ok);
        do_pin(16'h4321, 0, pi, adv, blq, early);
        model_txn(0, 32'd77, exp);
        do_txn(0, 32'd77, 0, obs, after);
        insert_card(0);
        for (int k = 0; k < 2; k++) begin
            model_pin(16'h0000, PIN, epi, eadv, eblq, ok);
            do_pin(16'h0000, 0, pi, adv, blq, early);
        end
        n_checks++;
        if (Advertencia !== eadv) begin
            n_fail++;
            $display("FAIL mid_pre_warning: got %b expected %b", Advertencia, eadv);
        end
        for (int k = 0; k < 2; k++) begin
            Digito = 4'(4 - k);
            Digito_STB = 1'b1;
            step();
            Digito_STB = 1'b0;
        end
        #2 Reset = 1'b0;
        #2;
        model_reset();
        n_checks++;
        if ({Balance_actualizado, Entregar_dinero, Fondos_insuficientes,
             PIN_incorrecto, Advertencia, Bloqueo} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b expected 000000",
                     {Balance_actualizado, Entregar_dinero, Fondos_insuficientes,
                      PIN_incorrecto, Advertencia, Bloqueo});
        end
        #1 Reset = 1'b1;
        step();
        insert_card(0);
        model_pin(16'h4321, PIN, epi, eadv, eblq, ok);
        do_pin(16'h4321, 0, pi, adv, blq, early);
        n_checks++;
        if ({pi, adv, early} !== {epi, eadv, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_fresh_pin: got pi/adv/early=%b%b%b expected %b%b0", pi, adv, early, epi, eadv);
        end
        model_txn(1, 32'd1001, exp);
        do_txn(1, 32'd1001, 0, obs, after);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL mid_balance_restored: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_random();
        logic pi, adv, blq, early, epi, eadv, eblq;
        logic [2:0] obs, after, exp;
        logic [15:0] pin, entered;
        logic [31:0] amt;
        bit ok, tipo;
        int tries;
        for (int s = 0; s < 30; s++) begin
            pin = 16'($urandom);
            PIN = pin;
            insert_card(1);
            tries = 0;
            do begin
                if (m_fails < 2 && $urandom_range(0, 2) == 0)
                    entered = pin ^ 16'($urandom_range(1, 65535));
                else
                    entered = pin;
                model_pin(entered, pin, epi, eadv, eblq, ok);
                do_pin(entered, 1, pi, adv, blq, early);
                n_checks++;
                if ({pi, adv, blq, early} !== {epi, eadv, eblq, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rand_pin s%0d pin=%h entered=%h: got pi/adv/blq/early=%b%b%b%b expected %b%b%b0",
                             s, pin, entered, pi, adv, blq, early, epi, eadv, eblq);
                end
                tries++;
            end while (!ok && tries < 10);
            tipo = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: amt = $urandom_range(0, 3000);
                1: amt = $urandom;
                2: amt = (m_bal <= 64'hFFFF_FFFF) ? m_bal[31:0] : $urandom;
                default: amt = 32'd0;
            endcase
            model_txn(tipo, amt, exp);
            do_txn(tipo, amt, 1, obs, after);
            n_checks++;
            if (obs !== exp || after !== 3'b000) begin
                n_fail++;
                $display("FAIL rand_txn s%0d tipo=%0d amt=%0d: got %b/%b expected %b/000",
                         s, tipo, amt, obs, after, exp);
            end
        end
    endtask

    initial begin
        Reset            = 1'b0;
        Tarjeta_recibida = 1'b0;
        PIN              = 16'h1234;
        Digito           = 4'd0;
        Digito_STB       = 1'b0;
        Tipo_trans       = 1'b0;
        Monto            = 32'd0;
        Monto_STB        = 1'b0;

        test_reset();
        test_deposit();
        test_withdraw();
        test_warning();
        test_lockout();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
